mssd_param_demux: RTL and testbench

//  Parametrised serial-to-multiport demultiplexer with integrated controller: parses a serial frame
//  (start bit, port number, byte count, payload) from serIn and forwards the payload, registered, to one
//  of NUM_PORTS outputs with per-port valid strobes. Adds busy, done and framing-error status.

---
 rtl/mssd_pkg.sv | 17 +
 rtl/mssd_down_counter.sv | 43 ++++
 rtl/mssd_param_demux.sv | 169 ++++++++++++++++
 tb/tb_mssd_param_demux.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mssd_pkg.sv
// Shared definitions for the serial-to-multiport demultiplexer.
//   state_e     : frame parser states (IDLE, PORT, LEN, DATA)
//   IDLE_LEVEL  : level of serIn between frames
//   START_LEVEL : level of serIn that marks a start bit
package mssd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PORT,
    LEN,
    DATA
  } state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/mssd_down_counter.sv
// Loadable down counter with terminal-count flag.
//   clk, reset : clock, synchronous active-high reset (clears count)
//   load       : load load_val (takes priority over en)
//   load_val   : value to load
//   en         : decrement by one (saturates at zero)
//   count      : current count
//   tc         : terminal count, high while count == 1
module mssd_down_counter #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == W'(1));

endmodule

// File: rtl/mssd_param_demux.sv
// Serial-to-multiport demultiplexer with frame controller.
// Frame on serIn: start bit, PORT_W-bit port number, LEN_W-bit byte count,
// then len*8 payload bits, all MSB first. Payload bits are forwarded one
// cycle after sampling to P[portNum] with a one-hot pValid strobe.
//   Clk      : clock (rising edge)
//   reset    : synchronous active-high reset
//   serIn    : serial frame input, idles high
//   P        : registered payload bit at the selected port index
//   pValid   : one-hot valid strobe for P
//   portNum  : last legal port field, held until the next legal one
//   busy     : high whenever the parser is not idle
//   done     : one-cycle pulse with the final payload pValid
//   frameErr : one-cycle pulse on zero length or out-of-range port
module mssd_param_demux
  import mssd_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 4,
  parameter  int unsigned LEN_W     = 4,
  localparam int unsigned PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 serIn,
  output logic [NUM_PORTS-1:0] P,
  output logic [NUM_PORTS-1:0] pValid,
  output logic [PORT_W-1:0]    portNum,
  output logic                 busy,
  output logic                 done,
  output logic                 frameErr
);

  localparam int unsigned FLD_MAX = (PORT_W > LEN_W) ? PORT_W : LEN_W;
  localparam int unsigned BC_W    = $clog2(FLD_MAX) + 1;
  localparam int unsigned CNT_W   = LEN_W + 3;

  state_e                 state_q, state_d;
  logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [PORT_W-1:0]      port_sh_q, port_sh_d;
  logic [LEN_W-1:0]       len_sh_q, len_sh_d;
  logic [PORT_W-1:0]      port_num_q, port_num_d;
  logic [NUM_PORTS-1:0]   p_q, p_d;
  logic [NUM_PORTS-1:0]   pvalid_q, pvalid_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;

  logic [PORT_W-1:0]      port_new;
  logic [LEN_W-1:0]       len_new;
  logic                   cnt_load;
  logic                   cnt_en;
  logic [CNT_W-1:0]       cnt_val;
  logic [CNT_W-1:0]       cnt_count;
  logic                   cnt_tc;

  // Field values including the bit being sampled this cycle; the truncating
  // cast keeps this valid when PORT_W is 1.
  assign port_new = PORT_W'({port_sh_q, serIn});
  assign len_new  = LEN_W'({len_sh_q, serIn});
  assign cnt_val  = {len_new, 3'b000};

  mssd_down_counter #(
    .W(CNT_W)
  ) u_payload_cnt (
    .clk     (Clk),
    .reset   (reset),
    .load    (cnt_load),
    .load_val(cnt_val),
    .en      (cnt_en),
    .count   (cnt_count),
    .tc      (cnt_tc)
  );

  // State and output registers
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      port_sh_q  <= '0;
      len_sh_q   <= '0;
      port_num_q <= '0;
      p_q        <= '0;
      pvalid_q   <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      port_sh_q  <= port_sh_d;
      len_sh_q   <= len_sh_d;
      port_num_q <= port_num_d;
      p_q        <= p_d;
      pvalid_q   <= pvalid_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    port_sh_d  = port_sh_q;
    len_sh_d   = len_sh_q;
    port_num_d = port_num_q;
    p_d        = '0;
    pvalid_d   = '0;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (serIn == START_LEVEL) begin
          state_d   = PORT;
          bit_cnt_d = '0;
        end
      end
      PORT: begin
        port_sh_d = port_new;
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        if (bit_cnt_q == BC_W'(PORT_W - 1)) begin
          bit_cnt_d = '0;
          if (32'(port_new) >= NUM_PORTS) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            port_num_d = port_new;
            state_d    = LEN;
          end
        end
      end
      LEN: begin
        len_sh_d  = len_new;
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        if (bit_cnt_q == BC_W'(LEN_W - 1)) begin
          bit_cnt_d = '0;
          if (len_new == '0) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_load = 1'b1;
            state_d  = DATA;
          end
        end
      end
      DATA: begin
        cnt_en               = 1'b1;
        p_d[port_num_q]      = serIn;
        pvalid_d[port_num_q] = 1'b1;
        if (cnt_tc) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    P        = p_q;
    pValid   = pvalid_q;
    portNum  = port_num_q;
    busy     = (state_q != IDLE);
    done     = done_q;
    frameErr = ferr_q;
  end

endmodule

// File: tb/tb_mssd_param_demux.sv
module tb_mssd_param_demux;
  import mssd_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       si4 = IDLE_LEVEL;
  logic       si3 = IDLE_LEVEL;

  logic [3:0] p4, pv4;
  logic [1:0] pn4;
  logic       busy4, done4, ferr4;
  logic [2:0] p3, pv3;
  logic [1:0] pn3;
  logic       busy3, done3, ferr3;

  mssd_param_demux #(.NUM_PORTS(4), .LEN_W(4)) dut4 (
    .Clk(clk), .reset(rst), .serIn(si4), .P(p4), .pValid(pv4),
    .portNum(pn4), .busy(busy4), .done(done4), .frameErr(ferr4)
  );

  mssd_param_demux #(.NUM_PORTS(3), .LEN_W(4)) dut3 (
    .Clk(clk), .reset(rst), .serIn(si3), .P(p3), .pValid(pv3),
    .portNum(pn3), .busy(busy3), .done(done3), .frameErr(ferr3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] p;
    logic [3:0] pv;
    logic [1:0] pn;
    logic       done;
    logic       ferr;
  } ev_t;

  ev_t        q4[$];
  ev_t        q3[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] exp_pn4 = 2'd0;
  logic [1:0] exp_pn3 = 2'd0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_out(input int sel, input logic b);
    if (sel == 4) si4 = b;
    else          si3 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int sel, input ev_t e);
    if (sel == 4) q4.push_back(e);
    else          q3.push_back(e);
  endtask

  // Drives one frame and queues the expected output events; nsend limits how
  // many payload bits are sent (fewer than len*8 when a reset will abort it).
  task automatic send_frame(input int sel, input int port, input int len,
                            input logic [15:0] data, input int nsend);
    int   nports;
    ev_t  e;
    logic b;
    nports = (sel == 4) ? 4 : 3;
    bit_out(sel, START_LEVEL);
    cmp("busy_after_start", 32'(sel == 4 ? busy4 : busy3), 32'd1);
    for (int i = 1; i >= 0; i--) begin
      if (i == 0 && port >= nports) begin
        e = '0;
        e.ferr = 1'b1;
        e.pn = (sel == 4) ? exp_pn4 : exp_pn3;
        push_ev(sel, e);
      end
      bit_out(sel, port[i]);
    end
    if (port >= nports) begin
      cmp("port_err_pulse", 32'(sel == 4 ? ferr4 : ferr3), 32'd1);
      cmp("busy_after_err", 32'(sel == 4 ? busy4 : busy3), 32'd0);
      bit_out(sel, IDLE_LEVEL);
      return;
    end
    if (sel == 4) exp_pn4 = 2'(port);
    else          exp_pn3 = 2'(port);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0 && len == 0) begin
        e = '0;
        e.ferr = 1'b1;
        e.pn = 2'(port);
        push_ev(sel, e);
      end
      bit_out(sel, len[i]);
    end
    if (len == 0) begin
      cmp("len_err_pulse", 32'(sel == 4 ? ferr4 : ferr3), 32'd1);
      cmp("busy_after_err", 32'(sel == 4 ? busy4 : busy3), 32'd0);
      if (sel == 4) si4 = IDLE_LEVEL;
      else          si3 = IDLE_LEVEL;
      return;
    end
    for (int k = 0; k < nsend; k++) begin
      b = data[15-k];
      e = '0;
      e.pv = 4'(1 << port);
      e.p = b ? e.pv : 4'd0;
      e.pn = 2'(port);
      e.done = (k == len * 8 - 1);
      push_ev(sel, e);
      bit_out(sel, b);
    end
    if (sel == 4) si4 = IDLE_LEVEL;
    else          si3 = IDLE_LEVEL;
    if (nsend == len * 8) begin
      cmp("busy_after_frame", 32'(sel == 4 ? busy4 : busy3), 32'd0);
    end
  endtask

  // Scoreboard monitors: pop one expected event per presented output cycle
  always @(negedge clk) begin
    ev_t e;
    if ((|pv4) || done4 || ferr4) begin
      if (q4.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dut4_unexpected: got P=%b pValid=%b done=%b frameErr=%b expected no output",
                 p4, pv4, done4, ferr4);
      end else begin
        e = q4.pop_front();
        cmp("dut4_output", 32'({p4, pv4, pn4, done4, ferr4}), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if ((|pv3) || done3 || ferr3) begin
      if (q3.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dut3_unexpected: got P=%b pValid=%b done=%b frameErr=%b expected no output",
                 p3, pv3, done3, ferr3);
      end else begin
        e = q3.pop_front();
        cmp("dut3_output", 32'({1'b0, p3, 1'b0, pv3, pn3, done3, ferr3}), 32'(e));
      end
    end
  end

  initial begin
    // Reset for two cycles while serIn toggles
    @(posedge clk);
    #1;
    repeat (2) begin
      si4 = ~si4;
      si3 = ~si3;
      @(posedge clk);
      #1;
    end
    cmp("rst_P4", 32'(p4), 32'd0);
    cmp("rst_pValid4", 32'(pv4), 32'd0);
    cmp("rst_portNum4", 32'(pn4), 32'd0);
    cmp("rst_busy4", 32'(busy4), 32'd0);
    cmp("rst_done4", 32'(done4), 32'd0);
    cmp("rst_frameErr4", 32'(ferr4), 32'd0);
    cmp("rst_pValid3", 32'(pv3), 32'd0);
    cmp("rst_busy3", 32'(busy3), 32'd0);
    rst = 1'b0;
    si4 = IDLE_LEVEL;
    si3 = IDLE_LEVEL;
    repeat (2) bit_out(4, IDLE_LEVEL);

    // Port 2, one byte 0xA5
    send_frame(4, 2, 1, 16'hA500, 8);
    cmp("portNum_after_A5", 32'(pn4), 32'd2);
    repeat (3) bit_out(4, IDLE_LEVEL);

    // Zero length to port 1
    send_frame(4, 1, 0, 16'h0000, 0);
    cmp("portNum_after_len0", 32'(pn4), 32'd1);
    repeat (2) bit_out(4, IDLE_LEVEL);

    // Back-to-back frames with no idle gap
    send_frame(4, 3, 2, 16'hC35A, 16);
    send_frame(4, 0, 1, 16'h9600, 8);
    repeat (2) bit_out(4, IDLE_LEVEL);

    // Reset in the middle of a port-1 payload
    send_frame(4, 1, 1, 16'hF000, 3);
    rst = 1'b1;
    bit_out(4, 1'b1);
    cmp("abort_pValid", 32'(pv4), 32'd0);
    cmp("abort_done", 32'(done4), 32'd0);
    cmp("abort_busy", 32'(busy4), 32'd0);
    cmp("abort_portNum", 32'(pn4), 32'd0);
    rst = 1'b0;
    exp_pn4 = 2'd0;
    exp_pn3 = 2'd0;
    si4 = IDLE_LEVEL;
    bit_out(4, IDLE_LEVEL);
    send_frame(4, 3, 1, 16'h3C00, 8);
    repeat (2) bit_out(4, IDLE_LEVEL);

    // Three-port instance: out-of-range port field
    send_frame(3, 2, 1, 16'h8100, 8);
    bit_out(3, IDLE_LEVEL);
    send_frame(3, 3, 1, 16'hFF00, 0);
    cmp("dut3_portNum_held", 32'(pn3), 32'd2);
    repeat (2) bit_out(3, IDLE_LEVEL);
    send_frame(3, 1, 1, 16'h7E00, 8);

    repeat (4) bit_out(3, IDLE_LEVEL);
    cmp("q4_drained", 32'(q4.size()), 32'd0);
    cmp("q3_drained", 32'(q3.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
